// File: rtl/acc_seq_arbiter_if.sv
// Bundle between the accumulator sequencer, its requesters and the
// accumulator register. The zero/carry flags exist only when
// ACC_SEQ_FLAGS_EN is defined.
interface acc_seq_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 8
);
    // Requester side
    logic [NREQ-1:0]   req;
    logic [2*NREQ-1:0] op;
    logic [W*NREQ-1:0] operand;
    logic [NREQ-1:0]   gnt;
    logic              done;
    logic [W-1:0]      result;
    logic              busy;
`ifdef ACC_SEQ_FLAGS_EN
    logic              zero;
    logic              carry;
`endif

    // Accumulator register side
    logic [W-1:0]      acc_d;
    logic              acc_load;
    logic [W-1:0]      acc_q;

    // Arbiter view
    modport slave (
        input  req, op, operand, acc_q,
        output gnt, done, result, busy, acc_d, acc_load
`ifdef ACC_SEQ_FLAGS_EN
        , output zero, carry
`endif
    );

    // Requester / accumulator environment view
    modport master (
        output req, op, operand, acc_q,
        input  gnt, done, result, busy, acc_d, acc_load
`ifdef ACC_SEQ_FLAGS_EN
        , input zero, carry
`endif
    );
endinterface

// File: rtl/acc_seq_arbiter.sv
// Round-robin arbiter and LOAD/ADD/SUB/READ sequencer sharing one
// accumulator register among NREQ requesters. Each grant runs
// IDLE -> EXEC -> COMMIT -> DONE; acc_load is high only in COMMIT.
// Optional flag outputs (zero, carry) are enabled by ACC_SEQ_FLAGS_EN.
module acc_seq_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    acc_seq_arbiter_if.slave bus
);
    localparam int PW = $clog2(NREQ);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EXEC   = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    logic [1:0]      state;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win_q;
    logic [1:0]      op_q;
    logic [W-1:0]    operand_q;

    logic [NREQ-1:0] gnt_q;
    logic            done_q;
    logic [W-1:0]    result_q;
    logic [W-1:0]    acc_d_q;
    logic            acc_load_q;

    logic [1:0]      op_arr      [NREQ];
    logic [W-1:0]    operand_arr [NREQ];
    logic            any_req;
    logic [PW-1:0]   win_next;
    logic [PW-1:0]   cand;
    logic [W-1:0]    next_val;

`ifdef ACC_SEQ_FLAGS_EN
    logic            zero_q;
    logic            carry_q;
    logic            carry_next;

    assign bus.zero  = zero_q;
    assign bus.carry = carry_q;
`endif

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.acc_d    = acc_d_q;
    assign bus.acc_load = acc_load_q;
    assign bus.busy     = (state != S_IDLE);

    // Split the flat per-requester buses into indexable arrays.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            op_arr[i]      = bus.op[2*i +: 2];
            operand_arr[i] = bus.operand[W*i +: W];
        end
    end

    // Round-robin search: first active request starting at ptr+1, wrapping.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        any_req  = 1'b0;
        win_next = ptr;
        cand     = ptr;
        for (int k = 1; k <= NREQ; k++) begin
            cand = PW'((int'(ptr) + k) % NREQ);
            if (!any_req && bus.req[cand]) begin
                any_req  = 1'b1;
                win_next = cand;
            end
        end
    end

    // Next accumulator value from the latched operation and the live acc_q.
    always_comb begin
        next_val = bus.acc_q;
        case (op_q)
            OP_LOAD: next_val = operand_q;
            OP_ADD:  next_val = bus.acc_q + operand_q;
            OP_SUB:  next_val = bus.acc_q - operand_q;
            default: next_val = bus.acc_q;
        endcase
    end

`ifdef ACC_SEQ_FLAGS_EN
    // Carry-out on ADD (sum wrapped below acc_q), borrow on SUB.
    always_comb begin
        carry_next = 1'b0;
        case (op_q)
            OP_ADD:  carry_next = (next_val < bus.acc_q);
            OP_SUB:  carry_next = (operand_q > bus.acc_q);
            default: carry_next = 1'b0;
        endcase
    end
`endif

    // Sequencer FSM: grant, compute, commit to the accumulator, report.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state      <= S_IDLE;
            ptr        <= PW'(NREQ - 1);
            win_q      <= '0;
            op_q       <= OP_LOAD;
            operand_q  <= '0;
            gnt_q      <= '0;
            done_q     <= 1'b0;
            result_q   <= '0;
            acc_d_q    <= '0;
            acc_load_q <= 1'b0;
`ifdef ACC_SEQ_FLAGS_EN
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        win_q     <= win_next;
                        op_q      <= op_arr[win_next];
                        operand_q <= operand_arr[win_next];
                        gnt_q     <= NREQ'(1) << win_next;
                        state     <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    acc_d_q    <= next_val;
                    result_q   <= next_val;
                    acc_load_q <= (op_q != OP_READ);
`ifdef ACC_SEQ_FLAGS_EN
                    zero_q     <= (next_val == '0);
                    carry_q    <= carry_next;
`endif
                    state      <= S_COMMIT;
                end
                S_COMMIT: begin
                    acc_load_q <= 1'b0;
                    done_q     <= 1'b1;
                    state      <= S_DONE;
                end
                S_DONE: begin
                    gnt_q  <= '0;
                    done_q <= 1'b0;
                    ptr    <= win_q;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_acc_seq_arbiter.sv
// Self-checking bench for acc_seq_arbiter: directed scenarios followed by
// randomized request traffic, checked against a transaction-level model of
// the round-robin order and accumulator arithmetic. Flag checks are active
// when ACC_SEQ_FLAGS_EN is defined.
module tb_acc_seq_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 8;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ADD  = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    logic clk = 1'b0;
    logic rst_n;

    logic [NREQ-1:0] req_v;
    logic [1:0]      op_v      [NREQ];
    logic [W-1:0]    operand_v [NREQ];
    logic [W-1:0]    acc_reg = 8'h00;

    int n_checks = 0;
    int n_errors = 0;
    int model_acc = 0;
    int model_ptr = NREQ - 1;

    acc_seq_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

    acc_seq_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.req   = req_v;
    assign bus.acc_q = acc_reg;
    for (genvar g = 0; g < NREQ; g++) begin : g_pack
        assign bus.op[2*g +: 2]      = op_v[g];
        assign bus.operand[W*g +: W] = operand_v[g];
    end

    // Stand-in for the accumulator register: loads d_in when load is high.
    always @(posedge clk) begin
        if (bus.acc_load) acc_reg <= bus.acc_d;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one arbitration from the current IDLE cycle (cycle 0) through cycle 4.
    task automatic run_op(input bit keep, input bit drop);
        int win;
        int o;
        int a;
        int expv;
        int cy;
        int ld;
        win = -1;
        for (int k = 1; k <= NREQ; k++) begin
            int idx;
            idx = (model_ptr + k) % NREQ;
            if (win < 0 && req_v[idx]) win = idx;
        end
        if (win < 0) begin
            check("stim_has_request", 0, 1);
            return;
        end
        o = int'(op_v[win]);
        a = int'(operand_v[win]);
        cy = 0;
        case (o)
            0:       expv = a;
            1: begin expv = (model_acc + a) % 256;       cy = (model_acc + a > 255) ? 1 : 0; end
            2: begin expv = (model_acc - a + 256) % 256; cy = (a > model_acc) ? 1 : 0; end
            default: expv = model_acc;
        endcase
        ld = (o != 3) ? 1 : 0;

        tick(); // cycle 1: EXEC
        check("gnt_c1", bus.gnt, 1 << win);
        check("acc_load_c1", bus.acc_load, 0);
        check("done_c1", bus.done, 0);
        check("busy_c1", bus.busy, 1);
        if (drop) req_v[win] = 1'b0;

        tick(); // cycle 2: COMMIT
        check("gnt_c2", bus.gnt, 1 << win);
        check("acc_load_c2", bus.acc_load, ld);
        check("acc_d_c2", bus.acc_d, expv);
        check("done_c2", bus.done, 0);

        tick(); // cycle 3: DONE
        check("gnt_c3", bus.gnt, 1 << win);
        check("done_c3", bus.done, 1);
        check("result_c3", bus.result, expv);
        check("acc_load_c3", bus.acc_load, 0);
        check("acc_q_c3", acc_reg, expv);
`ifdef ACC_SEQ_FLAGS_EN
        check("zero_c3", bus.zero, (expv == 0) ? 1 : 0);
        check("carry_c3", bus.carry, cy);
`endif
        model_acc = expv;
        model_ptr = win;
        if (keep) begin
            op_v[win]      = 2'($urandom);
            operand_v[win] = 8'($urandom);
        end else begin
            req_v[win] = 1'b0;
        end

        tick(); // cycle 4: IDLE
        check("gnt_c4", bus.gnt, 0);
        check("done_c4", bus.done, 0);
        check("busy_c4", bus.busy, 0);
        check("result_hold_c4", bus.result, expv);
    endtask

    task automatic single(input int idx, input logic [1:0] o, input logic [W-1:0] a);
        req_v[idx]     = 1'b1;
        op_v[idx]      = o;
        operand_v[idx] = a;
        run_op(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        model_ptr = NREQ - 1;
    endtask

    initial begin
        req_v = '0;
        for (int i = 0; i < NREQ; i++) begin
            op_v[i]      = OP_LOAD;
            operand_v[i] = '0;
        end
        do_reset();
        check("rst_gnt", bus.gnt, 0);
        check("rst_done", bus.done, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_acc_load", bus.acc_load, 0);
        check("rst_acc_d", bus.acc_d, 0);
        check("rst_result", bus.result, 0);
`ifdef ACC_SEQ_FLAGS_EN
        check("rst_zero", bus.zero, 0);
        check("rst_carry", bus.carry, 0);
`endif
        rst_n = 1'b1;

        // Single LOAD, ADD/SUB wrap-around, READ
        single(0, OP_LOAD, 8'h5A);
        single(1, OP_LOAD, 8'hFF);
        single(1, OP_ADD,  8'h01);
        check("add_wrap_value", bus.result, 8'h00);
        single(1, OP_SUB,  8'h01);
        check("sub_wrap_value", bus.result, 8'hFF);
        single(2, OP_LOAD, 8'h33);
        single(2, OP_READ, 8'hC4);
        check("read_acc_unchanged", acc_reg, 8'h33);

        // Contention: all requesters held high from reset
        req_v = '1;
        for (int i = 0; i < NREQ; i++) begin
            op_v[i]      = 2'($urandom);
            operand_v[i] = 8'($urandom);
        end
        do_reset();
        rst_n = 1'b1;
        for (int n = 0; n < 5; n++) begin
            run_op(1'b1, 1'b0);
            check("rr_order", model_ptr, n % NREQ);
        end
        req_v = '0;
        tick();

        // Reset during EXEC aborts the operation
        req_v[0]     = 1'b1;
        op_v[0]      = OP_LOAD;
        operand_v[0] = 8'($urandom) | 8'h01;
        tick();
        check("abort_gnt_exec", bus.gnt, 1);
        rst_n = 1'b0;
        tick();
        check("abort_gnt", bus.gnt, 0);
        check("abort_acc_load", bus.acc_load, 0);
        check("abort_done", bus.done, 0);
        check("abort_busy", bus.busy, 0);
        tick();
        check("abort_acc_unchanged", acc_reg, model_acc);
        req_v = '0;
        model_ptr = NREQ - 1;
        rst_n = 1'b1;
        tick();

        // Request dropped right after the grant still completes
        req_v[3]     = 1'b1;
        op_v[3]      = OP_ADD;
        operand_v[3] = 8'($urandom);
        run_op(1'b0, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            logic [NREQ-1:0] new_bits;
            new_bits = NREQ'($urandom) & ~req_v;
            if ((req_v | new_bits) == '0) new_bits[$urandom_range(0, NREQ - 1)] = 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                if (new_bits[i]) begin
                    op_v[i]      = 2'($urandom);
                    operand_v[i] = 8'($urandom);
                end
            end
            req_v = req_v | new_bits;
            run_op(1'($urandom), 1'($urandom_range(0, 3) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "timeout");
    end
endmodule
